// File: rtl/pwm_multi_axi.sv
// Multi-channel PWM with shared prescaler/period counter behind an AXI4-Lite slave.
// Shadow PERIOD/DUTY/CENTER registers move to active copies at each period boundary.
module pwm_multi_axi #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_CH-1:0]               pwm_out,
    output logic                            irq
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] W_CTRL     = IDX_W'(0);
    localparam logic [IDX_W-1:0] W_PRESCALE = IDX_W'(1);
    localparam logic [IDX_W-1:0] W_PERIOD   = IDX_W'(2);
    localparam logic [IDX_W-1:0] W_STATUS   = IDX_W'(3);
    localparam logic [IDX_W-1:0] W_POL      = IDX_W'(4);
    localparam logic [IDX_W-1:0] W_DUTY0    = IDX_W'(8);

    // AXI handshake state
    logic                          awready_reg;
    logic                          bvalid_reg;
    logic                          arready_reg;
    logic                          rvalid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

    // programmed (shadow) registers
    logic [2:0]        ctrl_reg;
    logic [15:0]       prescale_reg;
    logic [CNT_W-1:0]  period_reg;
    logic              pdone_reg;
    logic [NUM_CH-1:0] pol_reg;
    logic [CNT_W-1:0]  duty_reg [NUM_CH];

    logic [2:0]        ctrl_next;
    logic [15:0]       prescale_next;
    logic [CNT_W-1:0]  period_next;
    logic [NUM_CH-1:0] pol_next;
    logic [CNT_W-1:0]  duty_next [NUM_CH];
    logic              pdone_clr;

    // active copies used by the counter and comparators
    logic [CNT_W-1:0]  period_act_reg;
    logic              center_act_reg;
    logic [CNT_W-1:0]  duty_act_reg [NUM_CH];

    logic [15:0]       psc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              down_reg;
    logic              down_next;
    logic              tick;
    logic              pb;
    logic              load_act;

    logic [NUM_CH-1:0] pwm_reg;
    logic [NUM_CH-1:0] pwm_next;
    logic              irq_reg;

    logic                          wr_fire;
    logic                          rd_fire;
    logic [IDX_W-1:0]              wr_word;
    logic [IDX_W-1:0]              rd_word;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                          unused_addr_bits;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        for (int b = 0; b < 4; b++) begin
            strb_merge[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
    endfunction

    assign wr_word          = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_word          = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign wr_fire          = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire          = arready_reg & S_AXI_ARVALID;

    // Next shadow values include the write landing this cycle, so a write that
    // coincides with a period boundary is picked up by that boundary.
    always_comb begin
        ctrl_next     = ctrl_reg;
        prescale_next = prescale_reg;
        period_next   = period_reg;
        pol_next      = pol_reg;
        pdone_clr     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_next[i] = duty_reg[i];
        end
        if (wr_fire) begin
            if (wr_word == W_CTRL)
                ctrl_next = 3'(strb_merge(32'(ctrl_reg), S_AXI_WDATA, S_AXI_WSTRB));
            if (wr_word == W_PRESCALE)
                prescale_next = 16'(strb_merge(32'(prescale_reg), S_AXI_WDATA, S_AXI_WSTRB));
            if (wr_word == W_PERIOD)
                period_next = CNT_W'(strb_merge(32'(period_reg), S_AXI_WDATA, S_AXI_WSTRB));
            if (wr_word == W_POL)
                pol_next = NUM_CH'(strb_merge(32'(pol_reg), S_AXI_WDATA, S_AXI_WSTRB));
            if (wr_word == W_STATUS)
                pdone_clr = S_AXI_WSTRB[0] & S_AXI_WDATA[0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_word == W_DUTY0 + IDX_W'(i))
                    duty_next[i] = CNT_W'(strb_merge(32'(duty_reg[i]), S_AXI_WDATA, S_AXI_WSTRB));
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            W_CTRL:     rd_mux = 32'(ctrl_reg);
            W_PRESCALE: rd_mux = 32'(prescale_reg);
            W_PERIOD:   rd_mux = 32'(period_reg);
            W_STATUS:   rd_mux = 32'(pdone_reg);
            W_POL:      rd_mux = 32'(pol_reg);
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (rd_word == W_DUTY0 + IDX_W'(i))
                        rd_mux = 32'(duty_reg[i]);
                end
            end
        endcase
    end

    assign tick     = ctrl_reg[0] & (psc_reg >= prescale_reg);
    assign load_act = ~ctrl_reg[0] | pb;

    // Centre mode turns at PERIOD and bottoms out at 0; each endpoint is visited once.
    always_comb begin
        cnt_next  = cnt_reg;
        down_next = down_reg;
        pb        = 1'b0;
        if (!ctrl_reg[0]) begin
            cnt_next  = '0;
            down_next = 1'b0;
        end else if (tick) begin
            if (!center_act_reg) begin
                if (cnt_reg >= period_act_reg) begin
                    cnt_next = '0;
                    pb       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end else if (period_act_reg == '0) begin
                cnt_next  = '0;
                down_next = 1'b0;
                pb        = 1'b1;
            end else if (!down_reg && cnt_reg < period_act_reg) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end else if (cnt_reg <= CNT_W'(1)) begin
                cnt_next  = '0;
                down_next = 1'b0;
                pb        = 1'b1;
            end else begin
                cnt_next  = cnt_reg - CNT_W'(1);
                down_next = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign pwm_next[gi] = (ctrl_reg[0] & (cnt_reg < duty_act_reg[gi])) ^ pol_reg[gi];
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_reg    <= 1'b0;
            bvalid_reg     <= 1'b0;
            arready_reg    <= 1'b0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            ctrl_reg       <= '0;
            prescale_reg   <= '0;
            period_reg     <= '0;
            pdone_reg      <= 1'b0;
            pol_reg        <= '0;
            period_act_reg <= '0;
            center_act_reg <= 1'b0;
            psc_reg        <= '0;
            cnt_reg        <= '0;
            down_reg       <= 1'b0;
            pwm_reg        <= '0;
            irq_reg        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_reg[i]     <= '0;
                duty_act_reg[i] <= '0;
            end
        end else begin
            if (awready_reg)
                awready_reg <= 1'b0;
            else if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_reg)
                awready_reg <= 1'b1;

            if (wr_fire)
                bvalid_reg <= 1'b1;
            else if (S_AXI_BREADY)
                bvalid_reg <= 1'b0;

            if (arready_reg)
                arready_reg <= 1'b0;
            else if (S_AXI_ARVALID && !rvalid_reg)
                arready_reg <= 1'b1;

            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_reg <= 1'b0;
            end

            ctrl_reg     <= ctrl_next;
            prescale_reg <= prescale_next;
            period_reg   <= period_next;
            pol_reg      <= pol_next;
            pdone_reg    <= pb | (pdone_reg & ~pdone_clr);
            for (int i = 0; i < NUM_CH; i++) begin
                duty_reg[i] <= duty_next[i];
            end

            if (load_act) begin
                period_act_reg <= period_next;
                center_act_reg <= ctrl_next[1];
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_reg[i] <= duty_next[i];
                end
            end

            if (!ctrl_reg[0] || tick)
                psc_reg <= '0;
            else
                psc_reg <= psc_reg + 16'd1;

            cnt_reg  <= cnt_next;
            down_reg <= down_next;
            pwm_reg  <= pwm_next;
            irq_reg  <= ctrl_reg[2] & pdone_reg;
        end
    end

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = awready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = 2'b00;
    assign pwm_out       = pwm_reg;
    assign irq           = irq_reg;

endmodule

// File: tb/tb_pwm_multi_axi.sv
// Directed bench for pwm_multi_axi: register access, edge/centre PWM, shadowing,
// interrupt, polarity/disable and mid-run reset.
module tb_pwm_multi_axi;

    logic        clk = 1'b0;
    logic        srst;
    logic [5:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  pwm_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi_axi #(
        .NUM_CH(4), .CNT_W(16), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .ACLK(clk), .ARESET(srst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .pwm_out(pwm_out), .irq(irq)
    );

    // Waveform monitor for channel 0 and irq, sampled on the falling edge.
    int cyc = 0;
    int hi_run = 0;
    logic p0_prev = 1'b0;
    logic irq_prev = 1'b0;
    int runs[$];
    int gaps[$];
    int rises[$];
    int irq_rises[$];

    always @(negedge clk) begin
        cyc++;
        if (pwm_out[0]) begin
            if (!p0_prev) begin
                if (rises.size() > 0) gaps.push_back(cyc - rises[$]);
                rises.push_back(cyc);
            end
            hi_run++;
        end else if (hi_run > 0) begin
            runs.push_back(hi_run);
            hi_run = 0;
        end
        if (irq && !irq_prev) irq_rises.push_back(cyc);
        p0_prev  = pwm_out[0];
        irq_prev = irq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("aw_w_ready", 32'(awready & wready), 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bvalid_bresp", 32'({bvalid, bresp}), 32'b100);
        @(posedge clk);
        #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rvalid_rresp", 32'({rvalid, rresp}), 32'b100);
        d = rdata;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic wait_rise(input string tag);
        logic p;
        logic hit;
        hit = 1'b0;
        p = pwm_out[0];
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            hit = pwm_out[0] & ~p;
            p = pwm_out[0];
        end
        check({tag, "_rise"}, 32'(hit), 32'd1);
    endtask

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int ones1;
        int ones2;
        int ri;
        int r0;

        srst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ready", 32'({awready, wready, arready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        srst = 1'b0;

        // Register readback; STATUS is read first, before the first period boundary.
        axi_write(6'h0C, 32'd4, 4'hF);
        axi_write(6'h08, 32'd3, 4'hF);
        axi_write(6'h04, 32'd2, 4'hF);
        axi_write(6'h00, 32'd1, 4'hF);
        axi_read(6'h0C, d); check("status0", d, 32'd0);
        axi_read(6'h00, d); check("ctrl", d, 32'd1);
        axi_read(6'h04, d); check("prescale", d, 32'd2);
        axi_read(6'h08, d); check("period", d, 32'd3);
        axi_read(6'h3C, d); check("unmapped_3c", d, 32'd0);

        // Edge PWM: PERIOD written with only byte 0 enabled
        axi_write(6'h00, 32'd0, 4'hF);
        axi_write(6'h04, 32'd0, 4'hF);
        axi_write(6'h08, 32'hFFFF_FF09, 4'b0001);
        axi_read(6'h08, d); check("period_strb", d, 32'd9);
        axi_write(6'h20, 32'd3, 4'hF);
        axi_write(6'h24, 32'd0, 4'hF);
        axi_write(6'h28, 32'd10, 4'hF);
        axi_write(6'h14, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h14, d); check("unmapped_14", d, 32'd0);
        axi_read(6'h28, d); check("duty2_rb", d, 32'd10);
        axi_write(6'h00, 32'd1, 4'hF);
        repeat (30) @(negedge clk);
        runs.delete(); gaps.delete();
        ones1 = 0; ones2 = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ones1 += int'(pwm_out[1]);
            ones2 += int'(pwm_out[2]);
        end
        check("edge_ch1_ones", 32'(ones1), 32'd0);
        check("edge_ch2_ones", 32'(ones2), 32'd50);
        check("edge_ch0_high", 32'(last_of(runs)), 32'd3);
        check("edge_period", 32'(last_of(gaps)), 32'd10);

        // Shadow: DUTY0=7 written during a high run; that run stays 3, next is 7
        wait_rise("shadow");
        runs.delete();
        axi_write(6'h20, 32'd7, 4'hF);
        axi_read(6'h20, d); check("duty0_shadow_rb", d, 32'd7);
        repeat (25) @(negedge clk);
        check("shadow_cur", 32'((runs.size() > 0) ? runs[0] : -1), 32'd3);
        check("shadow_next", 32'((runs.size() > 1) ? runs[1] : -1), 32'd7);

        // Interrupt: rises with the second ch0 rise, 10 cycles after the first
        axi_write(6'h00, 32'd0, 4'hF);
        axi_write(6'h0C, 32'd1, 4'hF);
        rises.delete(); irq_rises.delete();
        axi_write(6'h00, 32'd5, 4'hF);
        repeat (20) @(negedge clk);
        ri = (irq_rises.size() > 0) ? irq_rises[0] : -1000;
        r0 = (rises.size() > 0) ? rises[0] : 0;
        check("irq_after_pb", 32'(ri - r0), 32'd10);
        axi_read(6'h0C, d); check("status_set", d, 32'd1);

        wait_rise("w1c");
        axi_write(6'h0C, 32'd1, 4'hF);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        axi_read(6'h0C, d); check("status_cleared", d, 32'd0);

        // W1C lands on the boundary edge (8 cycles after the ch0 rise)
        wait_rise("w1c_pb");
        repeat (6) @(negedge clk);
        axi_write(6'h0C, 32'd1, 4'hF);
        @(negedge clk);
        check("irq_set_wins", 32'(irq), 32'd1);
        axi_read(6'h0C, d); check("status_set_wins", d, 32'd1);

        // Polarity and disable, then restart from cnt=0
        axi_write(6'h10, 32'd1, 4'hF);
        wait_rise("pol");
        repeat (2) @(negedge clk);
        axi_write(6'h00, 32'd0, 4'hF);
        @(negedge clk);
        check("disable_pol", 32'(pwm_out), 32'h1);
        axi_write(6'h10, 32'd0, 4'hF);
        axi_write(6'h00, 32'd1, 4'hF);
        runs.delete();
        repeat (15) @(negedge clk);
        check("restart_run", 32'((runs.size() > 0) ? runs[0] : -1), 32'd7);

        // Centre PWM: cnt<4 covers 7 of 16 ticks, 2 cycles per tick
        axi_write(6'h00, 32'd0, 4'hF);
        axi_write(6'h04, 32'd1, 4'hF);
        axi_write(6'h08, 32'd8, 4'hF);
        axi_write(6'h20, 32'd4, 4'hF);
        axi_write(6'h00, 32'd3, 4'hF);
        repeat (40) @(negedge clk);
        runs.delete(); gaps.delete();
        repeat (80) @(negedge clk);
        check("centre_high", 32'(last_of(runs)), 32'd14);
        check("centre_period", 32'(last_of(gaps)), 32'd32);

        // Reset while ch0 is high
        wait_rise("rst_mid");
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        check("midrst_pwm", 32'(pwm_out), 32'd0);
        check("midrst_valid", 32'({bvalid, rvalid, irq}), 32'd0);
        srst = 1'b0;
        axi_read(6'h00, d); check("midrst_ctrl", d, 32'd0);
        axi_read(6'h08, d); check("midrst_period", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
